// File: rtl/debug_scan_slave_core_if.sv
// Scan-path strobes, capture inputs and held action/status outputs of the debug scan slave.
interface debug_scan_slave_core_if #(
    parameter int unsigned IR_W   = 2,
    parameter int unsigned DR_W   = 38,
    parameter int unsigned NUM_CH = 3
);
    logic                     vs_uir;
    logic                     vs_cdr;
    logic                     vs_sdr;
    logic                     vs_udr;
    logic [IR_W-1:0]          ir_in;
    logic                     tdi;
    logic [NUM_CH*DR_W-1:0]   cap_data;
    logic                     act_ready;
    logic                     tdo;
    logic [IR_W-1:0]          ir_out;
    logic [DR_W-1:0]          jdo;
    logic                     act_valid;
    logic [IR_W-1:0]          act_ch;
    logic                     act_take;
    logic [NUM_CH-1:0]        take_action;
    logic [NUM_CH-1:0]        take_no_action;
    logic                     overflow;
    logic                     scan_err;

    modport master (
        output vs_uir, vs_cdr, vs_sdr, vs_udr, ir_in, tdi, cap_data, act_ready,
        input  tdo, ir_out, jdo, act_valid, act_ch, act_take,
               take_action, take_no_action, overflow, scan_err
    );

    modport slave (
        input  vs_uir, vs_cdr, vs_sdr, vs_udr, ir_in, tdi, cap_data, act_ready,
        output tdo, ir_out, jdo, act_valid, act_ch, act_take,
               take_action, take_no_action, overflow, scan_err
    );
endinterface

// File: rtl/debug_scan_slave_core.sv
// Debug scan slave: DR shift register with per-instruction capture, held valid/ready
// action delivery, and sticky overflow / short-scan status.
module debug_scan_slave_core #(
    parameter int unsigned IR_W    = 2,
    parameter int unsigned DR_W    = 38,
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ACT_BIT = 34
) (
    input logic                   clk,
    input logic                   reset_n,
    debug_scan_slave_core_if.slave bus
);
    localparam int unsigned     CNT_W    = $clog2(DR_W + 2);
    localparam logic [IR_W-1:0] IR_CLEAR = '1;

    logic [DR_W-1:0]  sr,        sr_nxt;
    logic [IR_W-1:0]  ir_reg,    ir_reg_nxt;
    logic [DR_W-1:0]  jdo,       jdo_nxt;
    logic [IR_W-1:0]  act_ch,    act_ch_nxt;
    logic             act_take,  act_take_nxt;
    logic             act_valid, act_valid_nxt;
    logic             overflow,  overflow_nxt;
    logic             scan_err,  scan_err_nxt;
    logic [CNT_W-1:0] bit_cnt,   bit_cnt_nxt;

    logic             ch_ok;
    logic [DR_W-1:0]  cap_word;
    logic [NUM_CH-1:0] take_action, take_no_action;

    // CLEAR (all ones) is always >= NUM_CH, so one compare excludes it too
    assign ch_ok = (32'(ir_reg) < NUM_CH);

    always_comb begin
        cap_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_reg == IR_W'(k)) begin
                cap_word = bus.cap_data[k*DR_W +: DR_W];
            end
        end
    end

    always_comb begin
        sr_nxt        = sr;
        ir_reg_nxt    = ir_reg;
        jdo_nxt       = jdo;
        act_ch_nxt    = act_ch;
        act_take_nxt  = act_take;
        act_valid_nxt = act_valid;
        overflow_nxt  = overflow;
        scan_err_nxt  = scan_err;
        bit_cnt_nxt   = bit_cnt;

        if (act_valid && bus.act_ready) begin
            act_valid_nxt = 1'b0;
        end

        // strobe priority: uir > cdr > sdr > udr
        if (bus.vs_uir) begin
            ir_reg_nxt = bus.ir_in;
            if (bus.ir_in == IR_CLEAR) begin
                overflow_nxt = 1'b0;
                scan_err_nxt = 1'b0;
            end
        end else if (bus.vs_cdr) begin
            sr_nxt      = ch_ok ? cap_word : '0;
            bit_cnt_nxt = '0;
        end else if (bus.vs_sdr) begin
            sr_nxt = {bus.tdi, sr[DR_W-1:1]};
            if (bit_cnt != CNT_W'(DR_W + 1)) begin
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end else if (bus.vs_udr && ch_ok) begin
            if (bit_cnt != CNT_W'(DR_W)) begin
                scan_err_nxt = 1'b1;
            end else if (!act_valid || bus.act_ready) begin
                jdo_nxt       = sr;
                act_ch_nxt    = ir_reg;
                act_take_nxt  = sr[ACT_BIT];
                act_valid_nxt = 1'b1;
            end else begin
                overflow_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr        <= '0;
            ir_reg    <= '0;
            jdo       <= '0;
            act_ch    <= '0;
            act_take  <= 1'b0;
            act_valid <= 1'b0;
            overflow  <= 1'b0;
            scan_err  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            sr        <= sr_nxt;
            ir_reg    <= ir_reg_nxt;
            jdo       <= jdo_nxt;
            act_ch    <= act_ch_nxt;
            act_take  <= act_take_nxt;
            act_valid <= act_valid_nxt;
            overflow  <= overflow_nxt;
            scan_err  <= scan_err_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (act_valid && (act_ch == IR_W'(k))) begin
                take_action[k]    = act_take;
                take_no_action[k] = !act_take;
            end
        end
    end

    assign bus.tdo            = sr[0];
    assign bus.ir_out         = IR_W'({overflow, act_valid});
    assign bus.jdo            = jdo;
    assign bus.act_valid      = act_valid;
    assign bus.act_ch         = act_ch;
    assign bus.act_take       = act_take;
    assign bus.take_action    = take_action;
    assign bus.take_no_action = take_no_action;
    assign bus.overflow       = overflow;
    assign bus.scan_err       = scan_err;
endmodule

// File: tb/tb_debug_scan_slave_core.sv
// Bench for debug_scan_slave_core: directed scenarios plus randomized scans against a behavioural model.
module tb_debug_scan_slave_core;
    localparam int unsigned IR_W    = 2;
    localparam int unsigned DR_W    = 38;
    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned ACT_BIT = 34;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    debug_scan_slave_core_if #(.IR_W(IR_W), .DR_W(DR_W), .NUM_CH(NUM_CH)) bus();

    debug_scan_slave_core #(.IR_W(IR_W), .DR_W(DR_W), .NUM_CH(NUM_CH), .ACT_BIT(ACT_BIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // behavioural model state
    logic [DR_W-1:0] m_sr;
    int              m_cnt;
    int              m_ir;
    logic [DR_W-1:0] m_jdo;
    int              m_ch;
    bit              m_take, m_valid, m_ovf, m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic [3:0] s, input logic [IR_W-1:0] ir,
                              input logic t, input logic rdy);
        bit ch_ok;
        if (!rn) begin
            m_sr = '0; m_cnt = 0; m_ir = 0; m_jdo = '0; m_ch = 0;
            m_take = 0; m_valid = 0; m_ovf = 0; m_err = 0;
            return;
        end
        ch_ok = (m_ir < NUM_CH);
        if (m_valid && rdy) m_valid = 0;
        if (s[3]) begin
            m_ir = int'(ir);
            if (int'(ir) == (1 << IR_W) - 1) begin
                m_ovf = 0;
                m_err = 0;
            end
        end else if (s[2]) begin
            m_sr  = ch_ok ? bus.cap_data[m_ir*DR_W +: DR_W] : '0;
            m_cnt = 0;
        end else if (s[1]) begin
            m_sr = (m_sr >> 1);
            m_sr[DR_W-1] = t;
            if (m_cnt < DR_W + 1) m_cnt++;
        end else if (s[0] && ch_ok) begin
            if (m_cnt != DR_W) m_err = 1;
            else if (!m_valid) begin
                m_jdo = m_sr; m_ch = m_ir; m_take = m_sr[ACT_BIT]; m_valid = 1;
            end else m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] exp_ta, exp_tna;
        exp_ta  = (m_valid && m_take)  ? NUM_CH'(1 << m_ch) : '0;
        exp_tna = (m_valid && !m_take) ? NUM_CH'(1 << m_ch) : '0;
        chk("tdo",            64'(bus.tdo),            64'(m_sr[0]));
        chk("ir_out",         64'(bus.ir_out),         64'({m_ovf, m_valid}));
        chk("act_valid",      64'(bus.act_valid),      64'(m_valid));
        chk("overflow",       64'(bus.overflow),       64'(m_ovf));
        chk("scan_err",       64'(bus.scan_err),       64'(m_err));
        chk("take_action",    64'(bus.take_action),    64'(exp_ta));
        chk("take_no_action", 64'(bus.take_no_action), 64'(exp_tna));
        if (m_valid) begin
            chk("jdo",      64'(bus.jdo),      64'(m_jdo));
            chk("act_ch",   64'(bus.act_ch),   64'(m_ch));
            chk("act_take", 64'(bus.act_take), 64'(m_take));
        end
    endtask

    task automatic cycle(input logic rn, input logic [3:0] s, input logic [IR_W-1:0] ir,
                         input logic t, input logic rdy);
        reset_n       = rn;
        bus.vs_uir    = s[3];
        bus.vs_cdr    = s[2];
        bus.vs_sdr    = s[1];
        bus.vs_udr    = s[0];
        bus.ir_in     = ir;
        bus.tdi       = t;
        bus.act_ready = rdy;
        model_step(rn, s, ir, t, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_uir(input int ir, input logic rdy);
        cycle(1'b1, 4'b1000, IR_W'(ir), 1'b0, rdy);
    endtask

    task automatic do_cdr(input logic rdy);
        cycle(1'b1, 4'b0100, '0, 1'b0, rdy);
    endtask

    task automatic do_udr(input logic rdy);
        cycle(1'b1, 4'b0001, '0, 1'b0, rdy);
    endtask

    task automatic do_shift(input logic [DR_W-1:0] w, input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'b0010, '0, (i < DR_W) ? w[i] : 1'b0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 4'b0000, '0, 1'b0, rdy);
    endtask

    function automatic logic [DR_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DR_W-1:0];
    endfunction

    task automatic rand_cap();
        for (int k = 0; k < NUM_CH; k++) bus.cap_data[k*DR_W +: DR_W] = rand_word();
    endtask

    initial begin
        logic [DR_W-1:0] w1, w2, w3;
        bus.vs_uir = 0; bus.vs_cdr = 0; bus.vs_sdr = 0; bus.vs_udr = 0;
        bus.ir_in = '0; bus.tdi = 0; bus.act_ready = 0;
        rand_cap();

        // reset state
        cycle(1'b0, 4'b0000, '0, 1'b0, 1'b0);
        cycle(1'b0, 4'b0000, '0, 1'b0, 1'b0);
        chk("rst_ir_out", 64'(bus.ir_out), 64'd0);
        chk("rst_tdo", 64'(bus.tdo), 64'd0);
        chk("rst_take", 64'({bus.take_action, bus.take_no_action}), 64'd0);

        // capture ch1 and stream it out on tdo LSB-first
        w1 = 38'h2A_DEAD_BEEF;
        bus.cap_data[1*DR_W +: DR_W] = w1;
        do_uir(1, 1'b0);
        do_cdr(1'b0);
        for (int i = 0; i < DR_W; i++) begin
            chk("tdo_stream", 64'(bus.tdo), 64'(w1[i]));
            cycle(1'b1, 4'b0010, '0, 1'($urandom), 1'b0);
        end
        idle(2, 1'b0);
        chk("no_action_wo_udr", 64'(bus.act_valid), 64'd0);

        // take_action on ch0, held while not ready
        w2 = rand_word();
        w2[ACT_BIT] = 1'b1;
        do_uir(0, 1'b0);
        do_cdr(1'b0);
        do_shift(w2, DR_W, 1'b0);
        do_udr(1'b0);
        chk("ta_valid", 64'(bus.act_valid), 64'd1);
        chk("ta_onehot", 64'(bus.take_action), 64'b001);
        chk("ta_jdo", 64'(bus.jdo), 64'(w2));
        idle(5, 1'b0);
        chk("ta_held_jdo", 64'(bus.jdo), 64'(w2));
        chk("ta_held_valid", 64'(bus.act_valid), 64'd1);
        idle(1, 1'b1);
        chk("ta_released", 64'(bus.act_valid), 64'd0);

        // take_no_action on ch2, then overflow on a second scan
        w3 = rand_word();
        w3[ACT_BIT] = 1'b0;
        do_uir(2, 1'b0);
        do_cdr(1'b0);
        do_shift(w3, DR_W, 1'b0);
        do_udr(1'b0);
        chk("tna_onehot", 64'(bus.take_no_action), 64'b100);
        chk("tna_take_zero", 64'(bus.take_action), 64'd0);
        do_cdr(1'b0);
        do_shift(rand_word(), DR_W, 1'b0);
        do_udr(1'b0);
        chk("ovf_set", 64'(bus.overflow), 64'd1);
        chk("ovf_jdo_kept", 64'(bus.jdo), 64'(w3));
        chk("ovf_ir_out", 64'(bus.ir_out), 64'b11);

        // clear, then refill in the same cycle as the handshake
        do_uir(3, 1'b0);
        chk("clear_ovf", 64'(bus.overflow), 64'd0);
        do_uir(0, 1'b0);
        do_cdr(1'b0);
        w1 = rand_word();
        do_shift(w1, DR_W, 1'b0);
        do_udr(1'b1);
        chk("refill_valid", 64'(bus.act_valid), 64'd1);
        chk("refill_jdo", 64'(bus.jdo), 64'(w1));
        chk("refill_no_ovf", 64'(bus.overflow), 64'd0);
        idle(1, 1'b1);

        // short scan
        do_cdr(1'b0);
        do_shift(rand_word(), DR_W - 1, 1'b0);
        do_udr(1'b0);
        chk("short_err", 64'(bus.scan_err), 64'd1);
        chk("short_no_act", 64'(bus.act_valid), 64'd0);
        do_uir(3, 1'b0);
        chk("clear_err", 64'(bus.scan_err), 64'd0);

        // reset mid-handshake and mid-shift
        do_uir(1, 1'b0);
        do_cdr(1'b0);
        do_shift(rand_word(), DR_W, 1'b0);
        do_udr(1'b0);
        do_cdr(1'b0);
        do_shift(rand_word(), 10, 1'b0);
        cycle(1'b0, 4'b0010, '0, 1'b1, 1'b0);
        chk("midrst_valid", 64'(bus.act_valid), 64'd0);
        chk("midrst_jdo", 64'(bus.jdo), 64'd0);
        chk("midrst_ir_out", 64'(bus.ir_out), 64'd0);
        chk("midrst_tdo", 64'(bus.tdo), 64'd0);

        // uir and udr together: only IR updates
        do_uir(0, 1'b0);
        do_cdr(1'b0);
        do_shift(rand_word(), DR_W, 1'b0);
        cycle(1'b1, 4'b1001, IR_W'(2), 1'b0, 1'b0);
        chk("uir_udr_no_act", 64'(bus.act_valid), 64'd0);
        chk("uir_udr_no_err", 64'(bus.scan_err), 64'd0);
        do_cdr(1'b0);
        chk("uir_udr_ir2", 64'(bus.tdo), 64'(bus.cap_data[2*DR_W]));

        // randomized scans
        for (int sc = 0; sc < 120; sc++) begin
            int n, sel, rbias;
            rand_cap();
            rbias = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) do_uir($urandom_range(0, 3), 1'($urandom_range(0, 3) < rbias));
            do_cdr(1'($urandom_range(0, 3) < rbias));
            sel = $urandom_range(0, 9);
            n = (sel < 6) ? DR_W : (sel == 6) ? DR_W - 1 : (sel == 7) ? DR_W + 1 + $urandom_range(0, 3)
                                                                    : $urandom_range(0, DR_W);
            for (int i = 0; i < n; i++) begin
                logic [3:0] s;
                s = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'b0010;
                cycle(($urandom_range(0, 400) != 0), s, IR_W'($urandom), 1'($urandom),
                      1'($urandom_range(0, 3) < rbias));
            end
            do_udr(1'($urandom_range(0, 3) < rbias));
            idle($urandom_range(0, 3), 1'($urandom_range(0, 3) < rbias));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
